gs_ctrl: RTL
============

GS_CTRL -- requirements
Module: gs_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 256, meaning image width in pixels (power of two).
REQ-002 SHALL have parameter IMG_H, default 256, meaning image height in pixels; IMG_W*IMG_H = 65536 by default.
REQ-003 SHALL have parameter WDOG_MAX, default 1023, meaning the maximum number of idle cycles allowed between filter write-back beats.
REQ-004 SHALL have ports, clock and reset first:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  frm_start  in  1  one-cycle request to load and filter one frame
  abort  in  1  synchronous abort, any state
  host_wr_valid  in  1  host pixel beat valid
  host_wr_data  in  8  host pixel, row-major order
  host_wr_ready  out  1  host beat accepted when valid&ready
  flt_wr_valid  in  1  filter datapath result beat
  flt_wr_data  in  8  filter result pixel
  rd_start  out  1  one-cycle start pulse to the read address generator
  ram0_wr_en  out  1  ram0 write enable
  ram0_wr_addr  out  16  ram0 write address
  ram0_wr_data  out  8  ram0 write data
  ram1_wr_en  out  1  ram1 write enable
  ram1_wr_addr  out  16  ram1 write address
  ram1_wr_data  out  8  ram1 write data
  busy  out  1  high in any state other than IDLE
  frm_done  out  1  one-cycle completion pulse
  err_timeout  out  1  sticky watchdog error, cleared by the next accepted frm_start

Function
REQ-005 SHALL implement the FSM IDLE -> LOAD -> RUN_H -> RUN_V -> DONE -> IDLE; state is held in a registered 3-bit encoding.
REQ-006 IDLE: frm_start SHALL move the FSM to LOAD next cycle, clear the pixel counter and clear err_timeout; frm_start in any other state SHALL be ignored.
REQ-007 LOAD: host_wr_ready SHALL be 1; each accepted beat SHALL drive ram0 in the same cycle (combinational) with wr_en=1, addr=pix_cnt, data=host_wr_data, then pix_cnt increments.
REQ-008 LOAD: the beat accepted with pix_cnt = IMG_W*IMG_H-1 SHALL move the FSM to RUN_H, reset pix_cnt to 0 and assert rd_start for exactly the next cycle.
REQ-009 host_wr_ready SHALL be 0 outside LOAD; host beats presented outside LOAD SHALL be dropped without side effects.
REQ-010 RUN_H: each flt_wr_valid beat SHALL write ram1 with addr=pix_cnt (row-major {y,x}) and data=flt_wr_data; the last beat (pix_cnt = max) SHALL move the FSM to RUN_V and wrap pix_cnt to 0.
REQ-011 RUN_V: each flt_wr_valid beat SHALL write ram0 with addr={pix_cnt[7:0],pix_cnt[15:8]} (transposed back to row-major) and data=flt_wr_data; the last beat SHALL move the FSM to DONE.
REQ-012 DONE: frm_done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the following edge.
REQ-013 ram0_wr_en and ram1_wr_en SHALL never both be 1; wr_en=0 SHALL force the corresponding addr and data to 0.
REQ-014 The watchdog counter SHALL count cycles in RUN_H/RUN_V without flt_wr_valid and clear on every beat; reaching WDOG_MAX SHALL set err_timeout and force IDLE on the next edge.
REQ-015 The watchdog SHALL tolerate the pipeline fill (read generator line padding plus filter latency) with the default WDOG_MAX.
REQ-016 abort SHALL force IDLE on the next edge in any state, with all write enables, rd_start and frm_done low from that edge; abort has priority over every other transition.
REQ-017 Counter widths: pix_cnt SHALL be 16 bits, sized as clog2(IMG_W*IMG_H), and SHALL wrap naturally; the watchdog counter SHALL be 10 bits, sized as clog2(WDOG_MAX+1).
REQ-018 flt_wr_valid in IDLE, LOAD or DONE SHALL be ignored.

Reset
REQ-019 On rst_n=0 the FSM SHALL go to IDLE, pix_cnt and the watchdog SHALL clear, and every output SHALL be 0.
REQ-020 Reset mid-frame SHALL abandon the frame with no frm_done; a new frm_start after release SHALL restart from LOAD.

Structure
REQ-021 The shared package gs_pkg SHALL hold the state encodings, IMG_W/IMG_H defaults and the 16-bit address width constant.
REQ-022 gs_ctrl SHALL instantiate one sub-module, gs_wdog (the watchdog counter); the read address generator SHALL be instantiated at top level, beside gs_ctrl, not inside it.

Verification
REQ-023 frm_start, then 65536 back-to-back host beats with data=addr[7:0] -> ram0 written 0..65535, rd_start pulses one cycle after the last beat, busy=1.
REQ-024 In RUN_H, 65536 flt beats -> ram1 addr 0x0000..0xFFFF sequential; in RUN_V, beat n=0x0102 -> ram0_wr_addr=0x0201; frm_done pulses once, then IDLE.
REQ-025 In RUN_H, stall flt_wr_valid for 1024 cycles -> err_timeout=1 and IDLE; the next frm_start clears err_timeout.
REQ-026 abort asserted at pix_cnt=100 of LOAD -> IDLE next cycle, host_wr_ready=0, no frm_done; frm_start while busy -> no effect on state.
REQ-027 rst_n low during RUN_V -> all outputs 0 immediately; after release, a full frame completes normally.

Source files
------------

// File: rtl/gs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gs_pkg
// Brief   : Shared constants for the frame-filter controller: default image
//           geometry, RAM address width and FSM state encodings.
// Revision: 1.0 - initial release
// ============================================================================
package gs_pkg;

  // Default image geometry (power-of-two sides, 256x256 = 65536 pixels)
  localparam int C_IMG_W_DEF = 256;
  localparam int C_IMG_H_DEF = 256;

  // RAM address bus width
  localparam int C_AW = 16;

  // FSM state encodings
  localparam int              C_STW      = 3;
  localparam logic [C_STW-1:0] C_ST_IDLE  = 3'd0;
  localparam logic [C_STW-1:0] C_ST_LOAD  = 3'd1;
  localparam logic [C_STW-1:0] C_ST_RUN_H = 3'd2;
  localparam logic [C_STW-1:0] C_ST_RUN_V = 3'd3;
  localparam logic [C_STW-1:0] C_ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/gs_wdog.sv
`default_nettype none
// ============================================================================
// Module  : gs_wdog
// Brief   : Idle-cycle watchdog for the filter write-back stream. Counts
//           cycles without a beat while enabled; expire flags the cycle in
//           which the count already sits at WDOG_MAX and still no beat came.
// Revision: 1.0 - initial release
// ============================================================================
module gs_wdog #(
  parameter int WDOG_MAX = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic beat,
  output logic expire
);

  localparam int              CW        = $clog2(WDOG_MAX + 1);
  localparam logic [CW-1:0]   C_CNT_MAX = CW'(WDOG_MAX);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: clear when disabled or on a beat, otherwise count up and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (!en || beat) begin
      cnt_d = '0;
    end else if (cnt_q != C_CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With the default limit the budget comfortably covers line padding plus
  // filter latency, so only a genuinely stalled datapath trips this.
  assign expire = en && !beat && (cnt_q == C_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/gs_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gs_ctrl
// Brief   : Frame controller: loads a host frame into ram0, sequences the
//           horizontal pass (results to ram1) and the vertical pass (results
//           transposed back into ram0), with watchdog and abort. The read
//           address generator sits beside this block and is kicked by rd_start.
// Revision: 1.0 - initial release
// ============================================================================
module gs_ctrl
  import gs_pkg::*;
#(
  parameter int IMG_W    = C_IMG_W_DEF,
  parameter int IMG_H    = C_IMG_H_DEF,
  parameter int WDOG_MAX = 1023
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frm_start,
  input  logic            abort,
  input  logic            host_wr_valid,
  input  logic [7:0]      host_wr_data,
  output logic            host_wr_ready,
  input  logic            flt_wr_valid,
  input  logic [7:0]      flt_wr_data,
  output logic            rd_start,
  output logic            ram0_wr_en,
  output logic [C_AW-1:0] ram0_wr_addr,
  output logic [7:0]      ram0_wr_data,
  output logic            ram1_wr_en,
  output logic [C_AW-1:0] ram1_wr_addr,
  output logic [7:0]      ram1_wr_data,
  output logic            busy,
  output logic            frm_done,
  output logic            err_timeout
);

  localparam int               PIX_N      = IMG_W * IMG_H;
  localparam int               PIX_W      = $clog2(PIX_N);
  localparam int               YW         = $clog2(IMG_H);
  localparam logic [PIX_W-1:0] C_PIX_LAST = PIX_W'(PIX_N - 1);

  logic [C_STW-1:0] state_d,   state_q;
  logic [PIX_W-1:0] pix_cnt_d, pix_cnt_q;
  logic             err_d,     err_q;
  logic             rd_start_d, rd_start_q;

  logic             w_host_acc;
  logic             w_flt_acc;
  logic             w_run;
  logic             w_pix_last;
  logic             w_wdog_expire;
  logic [C_AW-1:0]  w_addr_lin;
  logic [C_AW-1:0]  w_addr_xpose;

  // Accepted beats only count in the state that owns that stream
  assign w_host_acc   = (state_q == C_ST_LOAD) && host_wr_valid;
  assign w_run        = (state_q == C_ST_RUN_H) || (state_q == C_ST_RUN_V);
  assign w_flt_acc    = w_run && flt_wr_valid;
  assign w_pix_last   = (pix_cnt_q == C_PIX_LAST);

  // Vertical pass arrives column-major {x,y}; swap back to row-major {y,x}
  assign w_addr_lin   = C_AW'(pix_cnt_q);
  assign w_addr_xpose = C_AW'({pix_cnt_q[YW-1:0], pix_cnt_q[PIX_W-1:YW]});

  gs_wdog #(
    .WDOG_MAX (WDOG_MAX)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_run),
    .beat   (flt_wr_valid),
    .expire (w_wdog_expire)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= C_ST_IDLE;
      pix_cnt_q  <= '0;
      err_q      <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      err_q      <= err_d;
      rd_start_q <= rd_start_d;
    end
  end

  // Next-state logic; abort outranks everything, then watchdog, then progress
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = C_ST_IDLE;
    end else begin
      case (state_q)
        C_ST_IDLE:  if (frm_start) state_d = C_ST_LOAD;
        C_ST_LOAD:  if (w_host_acc && w_pix_last) state_d = C_ST_RUN_H;
        C_ST_RUN_H: begin
          if (w_wdog_expire)                state_d = C_ST_IDLE;
          else if (w_flt_acc && w_pix_last) state_d = C_ST_RUN_V;
        end
        C_ST_RUN_V: begin
          if (w_wdog_expire)                state_d = C_ST_IDLE;
          else if (w_flt_acc && w_pix_last) state_d = C_ST_DONE;
        end
        C_ST_DONE:  state_d = C_ST_IDLE;
        default:    state_d = C_ST_IDLE;
      endcase
    end
  end

  // Pixel counter, sticky timeout flag and read-start pulse
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    err_d      = err_q;
    rd_start_d = 1'b0;
    if (abort) begin
      pix_cnt_d = '0;
    end else begin
      case (state_q)
        C_ST_IDLE: begin
          if (frm_start) begin
            pix_cnt_d = '0;
            err_d     = 1'b0;
          end
        end
        C_ST_LOAD: begin
          if (w_host_acc) begin
            pix_cnt_d  = pix_cnt_q + 1'b1;
            rd_start_d = w_pix_last;
          end
        end
        C_ST_RUN_H, C_ST_RUN_V: begin
          if (w_wdog_expire) begin
            err_d     = 1'b1;
            pix_cnt_d = '0;
          end else if (w_flt_acc) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; RAM ports are zeroed whenever their enable is low
  always_comb begin
    host_wr_ready = (state_q == C_ST_LOAD);
    busy          = (state_q != C_ST_IDLE);
    frm_done      = (state_q == C_ST_DONE);
    rd_start      = rd_start_q;
    err_timeout   = err_q;
    ram0_wr_en    = 1'b0;
    ram0_wr_addr  = '0;
    ram0_wr_data  = '0;
    ram1_wr_en    = 1'b0;
    ram1_wr_addr  = '0;
    ram1_wr_data  = '0;
    if (w_host_acc) begin
      ram0_wr_en   = 1'b1;
      ram0_wr_addr = w_addr_lin;
      ram0_wr_data = host_wr_data;
    end else if (w_flt_acc && (state_q == C_ST_RUN_V)) begin
      ram0_wr_en   = 1'b1;
      ram0_wr_addr = w_addr_xpose;
      ram0_wr_data = flt_wr_data;
    end
    if (w_flt_acc && (state_q == C_ST_RUN_H)) begin
      ram1_wr_en   = 1'b1;
      ram1_wr_addr = w_addr_lin;
      ram1_wr_data = flt_wr_data;
    end
  end

endmodule
`default_nettype wire
